// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared types, geometry defaults and pixel packing for the OV7670 capture path
package ov7670_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    CAPT
  } cap_state_t;

  typedef logic [11:0] rgb444_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int ADDR_W_DEF   = 19;

  // Keep the top four bits of each RGB565 channel; hi = {R4..R0,G5..G3}, lo = {G2..G0,B4..B0}.
  function automatic rgb444_t rgb565_to_444(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
  endfunction

endpackage

// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 byte-stream capture into a linear RGB444 frame-buffer write stream
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int DECIMATE = 0,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output rgb444_t           dout,
  output logic              frame_done,
  output logic              line_err
);

  localparam int FRAME_WORDS = (H_ACTIVE * V_ACTIVE) >> (2 * DECIMATE);
  localparam int PIX_W       = $clog2(H_ACTIVE + 1) + 1;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [PIX_W-1:0]  PIX_MAX   = '1;
  localparam logic [PIX_W-1:0]  PIX_LINE  = PIX_W'(H_ACTIVE);

  logic       vsync_q, vsync_qq;
  logic       href_q, href_qq;
  logic [7:0] d_q;
  logic       vsync_rise, vsync_fall, href_fall;

  cap_state_t       state;
  logic             phase;
  logic [7:0]       hi_byte;
  logic [PIX_W-1:0] pix_cnt;
  logic             line_odd;
  logic             full;
  logic             keep;

  // Register the camera pins once, plus a second copy of the strobes for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      href_q   <= 1'b0;
      href_qq  <= 1'b0;
      d_q      <= '0;
    end else begin
      vsync_q  <= vsync;
      vsync_qq <= vsync_q;
      href_q   <= href;
      href_qq  <= href_q;
      d_q      <= d;
    end
  end

  assign vsync_rise = vsync_q & ~vsync_qq;
  assign vsync_fall = ~vsync_q & vsync_qq;
  assign href_fall  = ~href_q & href_qq;

  // When decimating, only even pixels of even lines reach the frame buffer.
  assign keep = (DECIMATE == 0) || (!pix_cnt[0] && !line_odd);

  // Capture FSM with byte assembler, line checks and the frame-buffer write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we         <= 1'b0;
      addr       <= '0;
      dout       <= '0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      phase      <= 1'b0;
      hi_byte    <= '0;
      pix_cnt    <= '0;
      line_odd   <= 1'b0;
      full       <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      // Address advances the cycle after a write and saturates on the last word.
      if (we && addr != ADDR_LAST) begin
        addr <= addr + ADDR_W'(1);
      end
      if (!enable) begin
        state <= IDLE;
        phase <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            if (vsync_fall) begin
              addr     <= '0;
              pix_cnt  <= '0;
              line_odd <= 1'b0;
              phase    <= 1'b0;
              full     <= 1'b0;
              state    <= CAPT;
            end
          end
          CAPT: begin
            if (vsync_rise) begin
              frame_done <= 1'b1;
              phase      <= 1'b0;
              state      <= SYNC;
            end else if (href_q) begin
              if (!phase) begin
                hi_byte <= d_q;
                phase   <= 1'b1;
              end else begin
                phase <= 1'b0;
                if (pix_cnt != PIX_MAX) begin
                  pix_cnt <= pix_cnt + PIX_W'(1);
                end
                if (keep && !full) begin
                  we   <= 1'b1;
                  dout <= rgb565_to_444(hi_byte, d_q);
                  if (addr == ADDR_LAST) begin
                    full <= 1'b1;
                  end
                end
              end
            end else if (href_fall) begin
              if (phase || pix_cnt != PIX_LINE) begin
                line_err <= 1'b1;
              end
              phase    <= 1'b0;
              pix_cnt  <= '0;
              line_odd <= ~line_odd;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - randomized and table-driven bench for ov7670_capture against a frame-level model
module tb_ov7670_capture;

  localparam int H      = 8;
  localparam int V      = 6;
  localparam int AW     = 8;
  localparam int TOTAL0 = H * V;
  localparam int TOTAL1 = (H * V) / 4;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [11:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          vsync = 1'b1;
  logic          href = 1'b0;
  logic [7:0]    d = 8'h00;
  logic          we0, we1, fd0, fd1, le0, le1;
  logic [AW-1:0] addr0, addr1;
  logic [11:0]   dout0, dout1;

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIMATE(0), .ADDR_W(AW)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .vsync(vsync), .href(href), .d(d),
    .we(we0), .addr(addr0), .dout(dout0), .frame_done(fd0), .line_err(le0)
  );

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIMATE(1), .ADDR_W(AW)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .vsync(vsync), .href(href), .d(d),
    .we(we1), .addr(addr1), .dout(dout1), .frame_done(fd1), .line_err(le1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  wr_t  got0[$], got1[$], exp0[$], exp1[$];
  int   fd_cnt[2];
  int   fd_wide = 0;
  logic fd0_d = 1'b0;
  logic fd1_d = 1'b0;

  always @(negedge clk) begin
    if (we0) got0.push_back('{cyc, int'(addr0), int'(dout0)});
    if (we1) got1.push_back('{cyc, int'(addr1), int'(dout1)});
    if (fd0 && !fd0_d) fd_cnt[0]++;
    if (fd1 && !fd1_d) fd_cnt[1]++;
    if ((fd0 && fd0_d) || (fd1 && fd1_d)) fd_wide++;
    fd0_d = fd0;
    fd1_d = fd1;
  end

  // Frame-level model: mode 0 = disabled, 1 = waiting for a frame start, 2 = capturing.
  int         mode[2];
  int         wr[2];
  int         err[2];
  int         fdexp[2];
  int         line_i = 0;
  int         pix_i = 0;
  int         phase_m = 0;
  logic [7:0] hi_m = 8'h00;
  vec_t       tbl[H];

  function automatic int pack565(input int hi, input int lo);
    int r5, g6, b5;
    r5 = hi / 8;
    g6 = (hi % 8) * 8 + lo / 32;
    b5 = lo % 32;
    return (r5 / 2) * 256 + (g6 / 4) * 16 + (b5 / 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic cmp_q(input string nm, input wr_t e[$], input wr_t g[$]);
    chk({nm, " write count"}, g.size(), e.size());
    for (int i = 0; i < e.size() && i < g.size(); i++) begin
      n_total++;
      if (e[i].cyc == g[i].cyc && e[i].addr == g[i].addr && e[i].data == g[i].data) n_pass++;
      else $display("FAIL %s write %0d: got cyc=%0d addr=%0d dout=%03h expected cyc=%0d addr=%0d dout=%03h",
                    nm, i, g[i].cyc, g[i].addr, g[i].data, e[i].cyc, e[i].addr, e[i].data);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_pixel(input int hi, input int lo);
    int  tot;
    bit  take;
    wr_t e;
    for (int k = 0; k < 2; k++) begin
      if (mode[k] == 2) begin
        take = (k == 0) || ((pix_i % 2 == 0) && (line_i % 2 == 0));
        tot  = (k == 0) ? TOTAL0 : TOTAL1;
        if (take && wr[k] < tot) begin
          e = '{cyc + 2, wr[k], pack565(hi, lo)};
          if (k == 0) exp0.push_back(e);
          else exp1.push_back(e);
          wr[k]++;
        end
      end
    end
    pix_i++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    href = 1'b1;
    d    = b;
    if (phase_m == 0) begin
      hi_m    = b;
      phase_m = 1;
    end else begin
      model_pixel(int'(hi_m), int'(b));
      phase_m = 0;
    end
    ticks(1);
  endtask

  task automatic end_line();
    href = 1'b0;
    d    = 8'($urandom_range(0, 255));
    for (int k = 0; k < 2; k++)
      if (mode[k] == 2 && (phase_m != 0 || pix_i != H)) err[k] = 1;
    line_i++;
    pix_i   = 0;
    phase_m = 0;
    ticks(4);
  endtask

  task automatic drive_line(input int nbytes, input bit use_tbl);
    logic [7:0] v;
    for (int b = 0; b < nbytes; b++) begin
      if (use_tbl) v = (b % 2 == 1) ? tbl[b / 2].lo : tbl[b / 2].hi;
      else v = 8'($urandom_range(0, 255));
      send_byte(v);
    end
    end_line();
  endtask

  task automatic set_vsync(input logic v);
    if (v && !vsync) begin
      for (int k = 0; k < 2; k++)
        if (mode[k] == 2) begin
          fdexp[k]++;
          mode[k] = 1;
        end
    end else if (!v && vsync) begin
      for (int k = 0; k < 2; k++)
        if (mode[k] == 1) begin
          mode[k] = 2;
          wr[k]   = 0;
        end
      line_i  = 0;
      pix_i   = 0;
      phase_m = 0;
    end
    vsync = v;
  endtask

  task automatic set_enable(input logic v);
    enable = v;
    for (int k = 0; k < 2; k++) mode[k] = v ? ((mode[k] == 0) ? 1 : mode[k]) : 0;
  endtask

  task automatic drive_frame(input int nlines, input bit tbl_first);
    set_vsync(1'b0);
    ticks(3);
    for (int l = 0; l < nlines; l++) drive_line(2 * H, tbl_first && (l == 0));
    set_vsync(1'b1);
    ticks(4);
  endtask

  task automatic clear_q();
    got0.delete();
    got1.delete();
    exp0.delete();
    exp1.delete();
  endtask

  initial begin
    #200000;
    n_total++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    tbl[0] = '{8'hF8, 8'h1F, 12'hF0F};
    tbl[1] = '{8'h00, 8'h00, 12'h000};
    tbl[2] = '{8'hFF, 8'hFF, 12'hFFF};
    tbl[3] = '{8'h07, 8'hE0, 12'h0F0};
    tbl[4] = '{8'h08, 8'h01, 12'h000};
    tbl[5] = '{8'h10, 8'h02, 12'h101};
    tbl[6] = '{8'h04, 8'h20, 12'h080};
    tbl[7] = '{8'h7B, 8'hEF, 12'h777};
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0; wr[k] = 0; err[k] = 0; fdexp[k] = 0; fd_cnt[k] = 0;
    end

    ticks(3);
    rst = 1'b0;
    ticks(1);
    chk("reset we", we0, 0);
    chk("reset addr", addr0, 0);
    chk("reset dout", dout0, 0);
    chk("reset frame_done", fd0, 0);
    chk("reset line_err", le0, 0);

    // T1: disabled, a full frame goes by untouched.
    drive_frame(V, 1'b0);
    chk("t1 writes dut0", got0.size(), 0);
    chk("t1 writes dut1", got1.size(), 0);
    chk("t1 addr", addr0, 0);
    chk("t1 frame_done", fd_cnt[0], 0);

    // T2: enabled part-way through a frame; nothing is written until the next frame start.
    set_vsync(1'b0);
    ticks(3);
    drive_line(2 * H, 1'b0);
    drive_line(2 * H, 1'b0);
    set_enable(1'b1);
    ticks(3);
    drive_line(2 * H, 1'b0);
    drive_line(2 * H, 1'b0);
    set_vsync(1'b1);
    ticks(4);
    chk("t2 writes dut0", got0.size(), 0);
    chk("t2 frame_done", fd_cnt[0], fdexp[0]);

    // T3/T4/T6: full frame, first line from the packing table.
    drive_frame(V, 1'b1);
    for (int i = 0; i < H; i++) begin
      if (i < got0.size()) begin
        chk($sformatf("t3 addr px%0d", i), got0[i].addr, i);
        chk($sformatf("t3 dout px%0d", i), got0[i].data, tbl[i].exp);
      end else begin
        chk($sformatf("t3 missing px%0d", i), got0.size(), i + 1);
      end
    end
    cmp_q("t4 dut0", exp0, got0);
    cmp_q("t6 dut1", exp1, got1);
    chk("t4 write total", got0.size(), TOTAL0);
    if (got0.size() > 0) chk("t4 last addr", got0[got0.size() - 1].addr, TOTAL0 - 1);
    chk("t4 addr held", addr0, TOTAL0 - 1);
    chk("t6 write total", got1.size(), TOTAL1);
    chk("t6 addr held", addr1, TOTAL1 - 1);
    chk("t4 frame_done count", fd_cnt[0], fdexp[0]);
    chk("t6 frame_done count", fd_cnt[1], fdexp[1]);
    chk("t4 frame_done width", fd_wide, 0);
    chk("t4 line_err dut0", le0, 0);
    chk("t4 line_err dut1", le1, 0);
    clear_q();

    // T5: extra pixels after the last line, then an odd-length line.
    set_vsync(1'b0);
    ticks(3);
    for (int l = 0; l < V; l++) drive_line(2 * H, 1'b0);
    drive_line(20, 1'b0);
    drive_line(2 * H - 1, 1'b0);
    set_vsync(1'b1);
    ticks(4);
    cmp_q("t5 dut0", exp0, got0);
    cmp_q("t5 dut1", exp1, got1);
    chk("t5 addr saturated", addr0, TOTAL0 - 1);
    chk("t5 line_err dut0", le0, err[0]);
    chk("t5 line_err dut1", le1, err[1]);
    ticks(10);
    chk("t5 line_err sticky", le0, 1);
    clear_q();

    // T7: reset in the middle of a frame, then the next frame starts again at zero.
    set_vsync(1'b0);
    ticks(3);
    for (int l = 0; l < 3; l++) drive_line(2 * H, 1'b0);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mode[k] = 1; wr[k] = 0; err[k] = 0;
    end
    ticks(1);
    chk("t7 reset addr", addr0, 0);
    chk("t7 reset dout", dout0, 0);
    chk("t7 reset line_err", le0, 0);
    chk("t7 reset line_err dut1", le1, 0);
    chk("t7 reset we", we0, 0);
    rst = 1'b0;
    ticks(1);
    for (int l = 3; l < V; l++) drive_line(2 * H, 1'b0);
    set_vsync(1'b1);
    ticks(4);
    drive_frame(V, 1'b0);
    cmp_q("t7 dut0", exp0, got0);
    cmp_q("t7 dut1", exp1, got1);
    if (got0.size() > 0) chk("t7 first addr", got0[0].addr, 0);
    chk("t7 line_err", le0, 0);
    chk("t7 frame_done count", fd_cnt[0], fdexp[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
